// File: rtl/vec_mul_pkg.sv
// Shared types and default geometry for the vector-multiplier job sequencer.
// Imported by the sequencer, its interface and its delay line.
package vec_mul_pkg;

  localparam int ADDRESSSIZE_DEF = 10;
  localparam int PIPE_LAT_DEF    = 2;
  localparam int RELOAD_CYC_DEF  = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_W = 3'd1,
    RELOAD = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/vec_mul_sequencer_if.sv
// Datapath-facing bundle of the sequencer: Weight FIFO, PE reload, UB reads
// and Result SRAM writes. The master side is the sequencer.
interface vec_mul_sequencer_if
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE = ADDRESSSIZE_DEF
);

  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   weight_reload;
  logic [ADDRESSSIZE-1:0] ub_address;
  logic                   ub_valid;
  logic                   res_write_enable;
  logic [ADDRESSSIZE-1:0] res_address;

  modport master (
    input  fifo_empty,
    output fifo_read_enable,
    output weight_reload,
    output ub_address,
    output ub_valid,
    output res_write_enable,
    output res_address
  );

  modport slave (
    output fifo_empty,
    input  fifo_read_enable,
    input  weight_reload,
    input  ub_address,
    input  ub_valid,
    input  res_write_enable,
    input  res_address
  );

endinterface

// File: rtl/vec_mul_sequencer_delay.sv
// Fixed-depth valid shift register built from plain dff stages; clear empties
// every stage on the next edge so in-flight issues never turn into writes.
module valid_delay_line
  import vec_mul_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF
)(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic vld_in,
  output logic vld_out
);

  logic [DEPTH-1:0] vld_p;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (rst || clear) vld_p <= '0;
      else              vld_p <= vld_in;
    end
  end else begin : g_chain
    always_ff @(posedge clk) begin
      if (rst || clear) vld_p <= '0;
      else              vld_p <= {vld_p[DEPTH-2:0], vld_in};
    end
  end

  assign vld_out = vld_p[DEPTH-1];

endmodule

// File: rtl/vec_mul_sequencer.sv
// Runs one matrix-vector job: pop a weight tile, reload the PE array, stream
// N UB addresses and write each delayed result into Result SRAM.
module vec_mul_sequencer
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE = ADDRESSSIZE_DEF,
  parameter int PIPE_LAT    = PIPE_LAT_DEF,
  parameter int RELOAD_CYC  = RELOAD_CYC_DEF
)(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] vec_count,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  output logic                   busy,
  output logic                   done,
  vec_mul_sequencer_if.master    dp
);

  localparam int             RW          = (RELOAD_CYC > 1) ? $clog2(RELOAD_CYC) : 1;
  localparam logic [RW-1:0]  RELOAD_LAST = RW'(RELOAD_CYC - 1);
  localparam logic [ADDRESSSIZE-1:0] ONE = ADDRESSSIZE'(1);

  seq_state_e state_q, state_d;

  logic [ADDRESSSIZE-1:0] vec_count_q, src_base_q, dst_base_q;
  logic [ADDRESSSIZE-1:0] issue_cnt_q, wr_cnt_q;
  logic [RW-1:0]          reload_cnt_q;

  logic job_start, issue_now, write_now, last_issue, last_write;

  assign job_start  = (state_q == IDLE) && start && !abort;
  assign issue_now  = (state_q == STREAM);
  assign last_issue = (issue_cnt_q == vec_count_q - ONE);
  assign last_write = write_now && (wr_cnt_q + ONE == vec_count_q);

  always_ff @(posedge clk) begin
    if (rstn) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = (vec_count == '0) ? DONE : WAIT_W;
        WAIT_W:  if (!dp.fifo_empty) state_d = RELOAD;
        RELOAD:  if (reload_cnt_q == RELOAD_LAST) state_d = STREAM;
        STREAM:  if (last_issue) state_d = DRAIN;
        DRAIN:   if (last_write) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Job parameters are plain data: captured once per accepted start.
  always_ff @(posedge clk) begin
    if (job_start) begin
      vec_count_q <= vec_count;
      src_base_q  <= src_base;
      dst_base_q  <= dst_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn || abort || job_start) begin
      reload_cnt_q <= '0;
      issue_cnt_q  <= '0;
      wr_cnt_q     <= '0;
    end else begin
      if (state_q == RELOAD) reload_cnt_q <= reload_cnt_q + RW'(1);
      if (issue_now)         issue_cnt_q  <= issue_cnt_q + ONE;
      if (write_now)         wr_cnt_q     <= wr_cnt_q + ONE;
    end
  end

  // Write path: issue strobe delayed by the datapath latency, independent of state.
  valid_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_vld_delay (
    .clk     (clk),
    .rst     (rstn),
    .clear   (abort),
    .vld_in  (issue_now),
    .vld_out (write_now)
  );

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign dp.fifo_read_enable = (state_q == WAIT_W) && !dp.fifo_empty;
  assign dp.weight_reload    = (state_q == RELOAD);
  assign dp.ub_valid         = issue_now;
  assign dp.ub_address       = issue_now ? src_base_q + issue_cnt_q : '0;
  assign dp.res_write_enable = write_now;
  assign dp.res_address      = write_now ? dst_base_q + wr_cnt_q : '0;

endmodule

// File: doc/vec_mul_sequencer.md
# vec_mul_sequencer

Control FSM that runs one matrix-vector job on the 1x64 vector-multiplier datapath without host cycle-by-cycle driving. The host issues `start`. The block then pops one weight tile from the Weight FIFO, pulses `weight_reload`, streams N Unified Buffer addresses, and writes each result into Result SRAM after a fixed pipeline delay. It sits between the host/top-level control and the UB, Weight FIFO, vector multiplier and Result SRAM, replacing the free-running counter/valid-dff sequencing.

## Interface
Parameters:
- ADDRESSSIZE, 10, width of UB and Result SRAM addresses
- PIPE_LAT, 2, cycles from UB address issue to valid `result` at the Result SRAM input (≥1)
- RELOAD_CYC, 1, cycles `weight_reload` is held high per tile (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  one clock; reset is synchronous and active-high (rstn=1 resets on the next clk edge)
- start  in  1  job request, sampled only in IDLE
- abort  in  1  synchronous job cancel
- vec_count  in  ADDRESSSIZE  vectors in job, latched at start
- src_base  in  ADDRESSSIZE  first UB address, latched at start
- dst_base  in  ADDRESSSIZE  first Result SRAM address, latched at start
- fifo_empty  in  1  Weight FIFO empty flag
- fifo_read_enable  out  1  pop one weight tile
- weight_reload  out  1  load popped tile into PE array
- ub_address  out  ADDRESSSIZE  UB read address
- ub_valid  out  1  ub_address is a live issue
- res_write_enable  out  1  Result SRAM write strobe
- res_address  out  ADDRESSSIZE  Result SRAM write address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion

## Operation
- States: IDLE, WAIT_W, RELOAD, STREAM, DRAIN, DONE.
- IDLE: `start`=1 latches vec_count/src_base/dst_base. If vec_count==0, go to DONE; else go to WAIT_W.
- WAIT_W: `fifo_read_enable` = !fifo_empty (combinational from state and flag). Advance to RELOAD only on a cycle with fifo_empty=0. Stall indefinitely while empty.
- RELOAD: `weight_reload`=1 for exactly RELOAD_CYC cycles, then STREAM.
- STREAM: one issue per cycle. `ub_valid`=1 and `ub_address`=src_base+i for i=0..N-1, then DRAIN.
- DRAIN: holds until the write counter reaches N, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Write path: a PIPE_LAT-deep shift register carries ub_valid. Its output drives `res_write_enable`. res_address = dst_base + j, where j increments per write. The write path runs in any state, so the first writes overlap STREAM.
- Address arithmetic is modulo 2^ADDRESSSIZE: base+i wraps silently, no error.
- `start` in any state other than IDLE is ignored. There is no queueing.
- `abort`=1 in any state: next state IDLE, delay line cleared, counters zeroed, no `done`, no further writes. abort takes priority over all other transitions.
- rstn has priority over abort.

## Timing
- Reset values: all outputs 0, ub_address/res_address 0, state IDLE, delay line empty.
- Outputs are decoded from registered state and counters. `fifo_read_enable` additionally depends on fifo_empty.
- Cycle numbering, with start high at cycle 0 and the FIFO non-empty:
  - cycle 1: WAIT_W, pop
  - cycles 2..1+RELOAD_CYC: weight_reload
  - cycles 2+RELOAD_CYC .. 1+RELOAD_CYC+N: issues
  - first write at cycle 2+RELOAD_CYC+PIPE_LAT
  - last write at 1+RELOAD_CYC+N+PIPE_LAT
  - `done` one cycle after the last write
- Exactly one FIFO pop per job, and exactly N writes.
- vec_count==0: `done` at cycle 1, no pop, no reload, no writes.

## Structure
- Shared package `vec_mul_pkg`: state enum (IDLE..DONE) and the default ADDRESSSIZE/PIPE_LAT constants, shared with the top level.
- One sub-module, `valid_delay_line` (parameter DEPTH=PIPE_LAT, with clear input), reusing the existing `dff` cell style.
- Everything else lives in one file.

## Test plan
- Defaults, vec_count=4, src_base=0x010, dst_base=0x020, FIFO non-empty, start at cycle 0:
  - pop at cycle 1, reload at cycle 2
  - ub_address 0x010..0x013 at cycles 3–6
  - writes to 0x020..0x023 at cycles 5–8
  - done at cycle 9
- fifo_empty=1 for 5 cycles after start → stays in WAIT_W with no pop, then pops on the first non-empty cycle; all later timing shifts by 5.
- src_base=0x3FE, dst_base=0x3FF, vec_count=3 → ub_address 0x3FE, 0x3FF, 0x000; res_address 0x3FF, 0x000, 0x001.
- vec_count=0 → done at cycle 1, fifo_read_enable/weight_reload/res_write_enable never asserted.
- abort during STREAM after 2 issues → IDLE next cycle, no further writes beyond those already due in the same cycle, no done; a new start then runs a clean job.
- start re-asserted during DRAIN ignored. rstn=1 mid-STREAM → all outputs 0 on the next cycle, state IDLE.
